// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   common : default mul/div occupancies and the occupancy counter width.
//   pipes  : per-pipeline-register command encoding, the hazard FSM state
//            type and a helper that bundles five stage commands.

package common;
    localparam int unsigned MUL_LAT_DEFAULT = 3;
    localparam int unsigned DIV_LAT_DEFAULT = 65;
    // Wide enough for any occupancy in 1..127.
    localparam int unsigned CNT_W = 7;
endpackage : common

package pipes;
    // Command to one pipeline register for the coming clock edge.
    typedef enum logic [1:0] {
        WRITE     = 2'b00,  // load new contents
        FLUSH     = 2'b01,  // clear to a bubble
        HOLD      = 2'b10,  // keep contents
        HOLD_MARK = 2'b11   // keep contents and set the stalled flag
    } stage_ctrl_t;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        MD_BUSY    = 2'b01,
        FLUSH_PEND = 2'b10
    } hz_state_t;

    typedef struct packed {
        stage_ctrl_t f;
        stage_ctrl_t d;
        stage_ctrl_t e;
        stage_ctrl_t m;
        stage_ctrl_t w;
    } stage_cmds_t;

    function automatic stage_cmds_t mk_cmds(
        input stage_ctrl_t f,
        input stage_ctrl_t d,
        input stage_ctrl_t e,
        input stage_ctrl_t m,
        input stage_ctrl_t w
    );
        stage_cmds_t c;
        c.f = f;
        c.d = d;
        c.e = e;
        c.m = m;
        c.w = w;
        return c;
    endfunction
endpackage : pipes

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: hazard conditions reported by the pipeline and the
// per-stage commands returned to it.
//   master : pipeline side (drives hazard conditions, receives commands)
//   slave  : hazard_ctrl side (receives conditions, drives commands)

interface hazard_ctrl_if;
    import pipes::*;

    logic        i_busy;        // fetch outstanding, no response this cycle
    logic        d_busy;        // memory-stage load/store outstanding
    logic        load_use;      // decode depends on a load in execute
    logic        branch_taken;  // execute redirects the PC
    logic        md_start;      // execute holds a new mul/div op
    logic        md_is_div;     // that op is a divide

    stage_ctrl_t FWrite;
    stage_ctrl_t DWrite;
    stage_ctrl_t EWrite;
    stage_ctrl_t MWrite;
    stage_ctrl_t WWrite;
    logic        md_done;       // mul/div result valid this cycle
    logic        discard_fetch; // drop the ibus response arriving this cycle

    modport master (
        output i_busy, d_busy, load_use, branch_taken, md_start, md_is_div,
        input  FWrite, DWrite, EWrite, MWrite, WWrite, md_done, discard_fetch
    );

    modport slave (
        input  i_busy, d_busy, load_use, branch_taken, md_start, md_is_div,
        output FWrite, DWrite, EWrite, MWrite, WWrite, md_done, discard_fetch
    );
endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl_md_counter.sv
// md_counter: mul/div occupancy down-counter, also used by the execute unit.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val
//   load_val   : remaining cycles after the current one
//   dec        : decrement by one
//   freeze     : hold the count regardless of load/dec
//   count      : current count
//   last       : count == 1 (final occupancy cycle)

module md_counter
    import common::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    input  logic             freeze,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (freeze) begin
            count_reg <= count_reg;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign count = count_reg;
    assign last  = (count_reg == CNT_W'(1));

endmodule : md_counter

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush controller for a five-stage pipeline.
// Resolves memory stalls, multi-cycle mul/div occupancy, load-use hazards,
// taken branches and fetch stalls into one command per pipeline register.
// Commands are combinational from the FSM state and the current hazards.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_ctrl_if.slave (hazard inputs, stage commands,
//                md_done, discard_fetch)
// Parameters MUL_LAT / DIV_LAT: execute-stage occupancy in cycles, 1..127.

module hazard_ctrl
    import pipes::*;
    import common::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
    parameter int unsigned DIV_LAT = DIV_LAT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  bus
);

    // The start cycle is itself one cycle of occupancy.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);
    localparam bit               MUL_ONE  = (MUL_LAT == 1);
    localparam bit               DIV_ONE  = (DIV_LAT == 1);

    hz_state_t        state_reg;
    hz_state_t        state_next;
    stage_cmds_t      cmds;
    logic             md_done_c;
    logic             discard_c;
    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_load_val;
    logic [CNT_W-1:0] cnt_count;
    logic             cnt_last;
    logic             lat_one;

    md_counter u_md_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .freeze   (bus.d_busy),
        .count    (cnt_count),
        .last     (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = IDLE;
        cmds         = mk_cmds(WRITE, WRITE, WRITE, WRITE, WRITE);
        md_done_c    = 1'b0;
        discard_c    = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        cnt_load_val = bus.md_is_div ? DIV_LOAD : MUL_LOAD;
        lat_one      = bus.md_is_div ? DIV_ONE : MUL_ONE;

        if (reset) begin
            cmds = mk_cmds(FLUSH, FLUSH, FLUSH, FLUSH, FLUSH);
        end else if (bus.d_busy) begin
            // Everything up to memory waits; the memory op retires nothing.
            // State and counter freeze, so any pending branch is not taken
            // here and re-presents once execute advances.
            cmds       = mk_cmds(HOLD, HOLD_MARK, HOLD, HOLD, FLUSH);
            state_next = state_reg;
        end else if (state_reg == MD_BUSY) begin
            if (cnt_last) begin
                md_done_c = 1'b1;
                cmds      = mk_cmds(HOLD, HOLD_MARK, WRITE, WRITE, WRITE);
            end else begin
                cmds       = mk_cmds(HOLD, HOLD_MARK, HOLD, FLUSH, WRITE);
                cnt_dec    = 1'b1;
                state_next = MD_BUSY;
            end
        end else if (state_reg == FLUSH_PEND) begin
            // The wrong-path fetch is still in flight; its response must be
            // dropped when it finally arrives.
            if (bus.i_busy) begin
                cmds       = mk_cmds(HOLD, FLUSH, WRITE, WRITE, WRITE);
                state_next = FLUSH_PEND;
            end else begin
                discard_c = 1'b1;
                cmds      = mk_cmds(WRITE, FLUSH, WRITE, WRITE, WRITE);
            end
        end else if (bus.md_start) begin
            if (lat_one) begin
                md_done_c = 1'b1;
                cmds      = mk_cmds(HOLD, HOLD_MARK, WRITE, WRITE, WRITE);
            end else begin
                cmds       = mk_cmds(HOLD, HOLD_MARK, HOLD, FLUSH, WRITE);
                cnt_load   = 1'b1;
                state_next = MD_BUSY;
            end
        end else if (bus.load_use) begin
            cmds = mk_cmds(HOLD, HOLD_MARK, FLUSH, WRITE, WRITE);
        end else if (bus.branch_taken) begin
            if (bus.i_busy) begin
                cmds       = mk_cmds(HOLD, FLUSH, FLUSH, WRITE, WRITE);
                state_next = FLUSH_PEND;
            end else begin
                cmds = mk_cmds(WRITE, FLUSH, FLUSH, WRITE, WRITE);
            end
        end else if (bus.i_busy) begin
            cmds = mk_cmds(HOLD, FLUSH, WRITE, WRITE, WRITE);
        end
    end

    assign bus.FWrite        = cmds.f;
    assign bus.DWrite        = cmds.d;
    assign bus.EWrite        = cmds.e;
    assign bus.MWrite        = cmds.m;
    assign bus.WWrite        = cmds.w;
    assign bus.md_done       = md_done_c;
    assign bus.discard_fetch = discard_c;

    // The count value itself is consumed by the execute unit's own instance.
    logic unused_count;
    assign unused_count = ^cnt_count;

endmodule : hazard_ctrl
